// File: rtl/wb_stage_gen_pkg.sv
// Shared definitions for the write-back stage:
// bus layout helpers, exception codes, handler PC.
package wb_pkg;

  localparam int XLEN_D    = 32;
  localparam int RADDR_W_D = 5;
  localparam int ECODE_W_D = 6;
  localparam int CNT_W_D   = 64;

  localparam logic [31:0] EXC_ENTRY_D = 32'h1c008000;

  localparam logic [5:0] ECODE_INT  = 6'h00;
  localparam logic [5:0] ECODE_PIL  = 6'h01;
  localparam logic [5:0] ECODE_PIS  = 6'h02;
  localparam logic [5:0] ECODE_ADEF = 6'h08;
  localparam logic [5:0] ECODE_ALE  = 6'h09;
  localparam logic [5:0] ECODE_SYS  = 6'h0b;
  localparam logic [5:0] ECODE_BRK  = 6'h0c;
  localparam logic [5:0] ECODE_INE  = 6'h0d;

  // Bus layout, MSB first:
  // gr_we, exc, ertn, ecode, dest, result, pc
  function automatic int bus_w(
    int xlen,
    int raddr_w,
    int ecode_w
  );
    return 3 + ecode_w + raddr_w + 2 * xlen;
  endfunction

  function automatic int off_pc();
    return 0;
  endfunction

  function automatic int off_result(int xlen);
    return xlen;
  endfunction

  function automatic int off_dest(int xlen);
    return 2 * xlen;
  endfunction

  function automatic int off_ecode(
    int xlen,
    int raddr_w
  );
    return 2 * xlen + raddr_w;
  endfunction

  function automatic int off_ertn(
    int xlen,
    int raddr_w,
    int ecode_w
  );
    return off_ecode(xlen, raddr_w) + ecode_w;
  endfunction

  function automatic int off_exc(
    int xlen,
    int raddr_w,
    int ecode_w
  );
    return off_ertn(xlen, raddr_w, ecode_w) + 1;
  endfunction

  function automatic int off_gr_we(
    int xlen,
    int raddr_w,
    int ecode_w
  );
    return off_ertn(xlen, raddr_w, ecode_w) + 2;
  endfunction

endpackage

// File: rtl/wb_stage_gen_if.sv
// MA -> WB handshake: valid, payload bus and
// the WB back-pressure signal.
interface wb_stage_gen_if #(
  parameter int BUS_W = wb_pkg::bus_w(
    wb_pkg::XLEN_D,
    wb_pkg::RADDR_W_D,
    wb_pkg::ECODE_W_D
  )
);

  logic             ma_validout;
  logic [BUS_W-1:0] ma_to_wb_bus;
  logic             wb_allowin;

  modport master (
    output ma_validout,
    output ma_to_wb_bus,
    input  wb_allowin
  );

  modport slave (
    input  ma_validout,
    input  ma_to_wb_bus,
    output wb_allowin
  );

endinterface

// File: rtl/wb_stage_gen_retire_cnt.sv
// Retired-instruction counter, wraps at
// 2^CNT_W.
module wb_retire_cnt #(
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: +1 per retired instruction.
  always_comb begin
    cnt_d = cnt_q;
    if (inc) cnt_d = cnt_q + CNT_W'(1);
  end

  // Count register, cleared by sync reset.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/wb_stage_gen.sv
// Write-back stage: commits to the regfile,
// raises exception/ertn flushes, keeps era/ecode.
module wb_stage_gen
  import wb_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5,
  parameter int ECODE_W = 6,
  parameter int CNT_W   = 64,
  parameter logic [XLEN-1:0] EXC_ENTRY =
    XLEN'(EXC_ENTRY_D)
) (
  input  logic               clk,
  input  logic               rst,
  wb_stage_gen_if.slave      ma_if,
  input  logic               other_allowin,
  output logic               wb_validout,
  output logic               wb_rf_we,
  output logic [RADDR_W-1:0] wb_rf_waddr,
  output logic [XLEN-1:0]    wb_rf_wdata,
  output logic               wb_fwd_valid,
  output logic [RADDR_W-1:0] wb_fwd_dest,
  output logic [XLEN-1:0]    wb_fwd_data,
  output logic               wb_flush,
  output logic [XLEN-1:0]    wb_flush_target,
  output logic [XLEN-1:0]    csr_era,
  output logic [ECODE_W-1:0] csr_ecode,
  output logic [CNT_W-1:0]   retired_cnt,
  output logic [XLEN-1:0]    debug_wb_pc,
  output logic [3:0]         debug_wb_rf_we,
  output logic [RADDR_W-1:0] debug_wb_rf_wnum,
  output logic [XLEN-1:0]    debug_wb_rf_wdata
);

  localparam int BUS_W =
    bus_w(XLEN, RADDR_W, ECODE_W);

  localparam int O_PC  = off_pc();
  localparam int O_RES = off_result(XLEN);
  localparam int O_DST = off_dest(XLEN);
  localparam int O_EC  =
    off_ecode(XLEN, RADDR_W);
  localparam int O_RT  =
    off_ertn(XLEN, RADDR_W, ECODE_W);
  localparam int O_EX  =
    off_exc(XLEN, RADDR_W, ECODE_W);
  localparam int O_WE  =
    off_gr_we(XLEN, RADDR_W, ECODE_W);

  logic               valid_q;
  logic               valid_d;
  logic [BUS_W-1:0]   bus_q;
  logic [BUS_W-1:0]   bus_d;
  logic [XLEN-1:0]    era_q;
  logic [XLEN-1:0]    era_d;
  logic [ECODE_W-1:0] ecode_q;
  logic [ECODE_W-1:0] ecode_d;

  logic               gr_we;
  logic               exc;
  logic               ertn;
  logic [ECODE_W-1:0] ecode;
  logic [RADDR_W-1:0] dest;
  logic [XLEN-1:0]    result;
  logic [XLEN-1:0]    pc;

  logic allowin;
  logic commit;
  logic flush;
  logic rf_we;

  assign gr_we  = bus_q[O_WE];
  assign exc    = bus_q[O_EX];
  assign ertn   = bus_q[O_RT];
  assign ecode  = bus_q[O_EC +: ECODE_W];
  assign dest   = bus_q[O_DST +: RADDR_W];
  assign result = bus_q[O_RES +: XLEN];
  assign pc     = bus_q[O_PC +: XLEN];

  // Handshake, commit and write qualification.
  always_comb begin
    allowin = ~valid_q | other_allowin;
    commit  = valid_q & other_allowin;
    flush   = commit & (exc | ertn);
    rf_we   = valid_q & gr_we & ~exc
            & (dest != '0);
  end

  // Next state: a flush drops the incoming
  // instruction; exceptions capture pc/ecode.
  always_comb begin
    valid_d = valid_q;
    bus_d   = bus_q;
    era_d   = era_q;
    ecode_d = ecode_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (allowin) begin
      valid_d = ma_if.ma_validout;
      if (ma_if.ma_validout)
        bus_d = ma_if.ma_to_wb_bus;
    end
    if (commit & exc) begin
      era_d   = pc;
      ecode_d = ecode;
    end
  end

  // Stage and CSR registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      bus_q   <= '0;
      era_q   <= '0;
      ecode_q <= '0;
    end else begin
      valid_q <= valid_d;
      bus_q   <= bus_d;
      era_q   <= era_d;
      ecode_q <= ecode_d;
    end
  end

  wb_retire_cnt #(
    .CNT_W (CNT_W)
  ) u_retire (
    .clk (clk),
    .rst (rst),
    .inc (commit & ~exc),
    .cnt (retired_cnt)
  );

  assign ma_if.wb_allowin = allowin;
  assign wb_validout      = valid_q;

  assign wb_rf_we    = rf_we;
  assign wb_rf_waddr = dest;
  assign wb_rf_wdata = result;

  assign wb_fwd_valid = rf_we;
  assign wb_fwd_dest  =
    dest & {RADDR_W{valid_q}};
  assign wb_fwd_data  = result;

  assign wb_flush        = flush;
  assign wb_flush_target =
    exc ? EXC_ENTRY : era_q;

  assign csr_era   = era_q;
  assign csr_ecode = ecode_q;

  assign debug_wb_pc       = pc;
  assign debug_wb_rf_we    = {4{rf_we}};
  assign debug_wb_rf_wnum  = dest;
  assign debug_wb_rf_wdata = result;

endmodule

// File: tb/tb_wb_stage_gen.sv
// Scoreboard bench for wb_stage_gen: a queue
// model of the WB slot predicts every cycle.
module tb_wb_stage_gen;

  localparam int BW = 78;
  localparam logic [31:0] ENTRY = 32'h1c008000;

  typedef struct {
    bit          gr_we;
    bit          exc;
    bit          ertn;
    logic [5:0]  ecode;
    logic [4:0]  dest;
    logic [31:0] result;
    logic [31:0] pc;
  } ins_t;

  typedef struct {
    bit              skip;
    bit              post_rst;
    bit              valid;
    bit              allowin;
    bit              rf_we;
    bit              flush;
    logic [4:0]      waddr;
    logic [31:0]     wdata;
    logic [31:0]     target;
    logic [31:0]     pc;
    logic [31:0]     era;
    logic [5:0]      ecode;
    longint unsigned cnt;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          ma_validout;
  logic          other_allowin;
  logic [BW-1:0] bus;

  logic        wb_validout, wb_rf_we;
  logic [4:0]  wb_rf_waddr, wb_fwd_dest;
  logic [31:0] wb_rf_wdata, wb_fwd_data;
  logic        wb_fwd_valid, wb_flush;
  logic [31:0] wb_flush_target, csr_era;
  logic [5:0]  csr_ecode;
  logic [63:0] retired_cnt;
  logic [31:0] debug_wb_pc, debug_wb_rf_wdata;
  logic [3:0]  debug_wb_rf_we;
  logic [4:0]  debug_wb_rf_wnum;

  logic        v4, we4, fv4, fl4;
  logic [4:0]  wa4, fd4, wn4;
  logic [31:0] wd4, fdat4, ft4, era4, pc4, dd4;
  logic [5:0]  ec4;
  logic [3:0]  cnt4, dwe4;

  int total = 0;
  int bad   = 0;

  exp_t exp_q[$];
  ins_t slot[$];
  logic [31:0]     m_era = '0;
  logic [5:0]      m_ecode = '0;
  longint unsigned m_cnt = 0;
  bit known = 0;
  bit post_rst = 0;

  wb_stage_gen_if ma_if ();
  wb_stage_gen_if ma_if4 ();

  assign ma_if.ma_validout   = ma_validout;
  assign ma_if.ma_to_wb_bus  = bus;
  assign ma_if4.ma_validout  = ma_validout;
  assign ma_if4.ma_to_wb_bus = bus;

  always #5 clk = ~clk;

  wb_stage_gen dut (
    .clk               (clk),
    .rst               (rst),
    .ma_if             (ma_if),
    .other_allowin     (other_allowin),
    .wb_validout       (wb_validout),
    .wb_rf_we          (wb_rf_we),
    .wb_rf_waddr       (wb_rf_waddr),
    .wb_rf_wdata       (wb_rf_wdata),
    .wb_fwd_valid      (wb_fwd_valid),
    .wb_fwd_dest       (wb_fwd_dest),
    .wb_fwd_data       (wb_fwd_data),
    .wb_flush          (wb_flush),
    .wb_flush_target   (wb_flush_target),
    .csr_era           (csr_era),
    .csr_ecode         (csr_ecode),
    .retired_cnt       (retired_cnt),
    .debug_wb_pc       (debug_wb_pc),
    .debug_wb_rf_we    (debug_wb_rf_we),
    .debug_wb_rf_wnum  (debug_wb_rf_wnum),
    .debug_wb_rf_wdata (debug_wb_rf_wdata)
  );

  wb_stage_gen #(.CNT_W(4)) dut4 (
    .clk               (clk),
    .rst               (rst),
    .ma_if             (ma_if4),
    .other_allowin     (other_allowin),
    .wb_validout       (v4),
    .wb_rf_we          (we4),
    .wb_rf_waddr       (wa4),
    .wb_rf_wdata       (wd4),
    .wb_fwd_valid      (fv4),
    .wb_fwd_dest       (fd4),
    .wb_fwd_data       (fdat4),
    .wb_flush          (fl4),
    .wb_flush_target   (ft4),
    .csr_era           (era4),
    .csr_ecode         (ec4),
    .retired_cnt       (cnt4),
    .debug_wb_pc       (pc4),
    .debug_wb_rf_we    (dwe4),
    .debug_wb_rf_wnum  (wn4),
    .debug_wb_rf_wdata (dd4)
  );

  function automatic logic [BW-1:0] pack(ins_t i);
    return {i.gr_we, i.exc, i.ertn, i.ecode,
            i.dest, i.result, i.pc};
  endfunction

  function automatic ins_t mk(
    bit g, bit x, bit r, logic [5:0] ec,
    logic [4:0] d, logic [31:0] res,
    logic [31:0] pc
  );
    ins_t i;
    i.gr_we = g; i.exc = x; i.ertn = r;
    i.ecode = ec; i.dest = d;
    i.result = res; i.pc = pc;
    return i;
  endfunction

  function automatic ins_t rnd_ins();
    return mk(1'($urandom), $urandom % 8 == 0,
              $urandom % 8 == 0, 6'($urandom),
              5'($urandom), $urandom, $urandom);
  endfunction

  task automatic chk(string n, logic [63:0] a,
                     logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h @%0t",
               n, a, e, $time);
    end
  endtask

  // Reference: the stage is a one-entry queue.
  // Expected outputs come from the queue head and
  // the architectural era/ecode/count.
  task automatic step(bit r, bit mv, bit oa,
                      ins_t in);
    exp_t e;
    ins_t f;
    e = '{default: 0};
    e.skip     = !known;
    e.post_rst = post_rst;
    e.valid    = slot.size() != 0;
    e.allowin  = !e.valid || oa;
    e.era      = m_era;
    e.ecode    = m_ecode;
    e.cnt      = m_cnt;
    if (e.valid) begin
      f = slot[0];
      e.rf_we  = f.gr_we && !f.exc && f.dest != 0;
      e.waddr  = f.dest;
      e.wdata  = f.result;
      e.pc     = f.pc;
      e.target = f.exc ? ENTRY : m_era;
      e.flush  = oa && (f.exc || f.ertn);
    end
    exp_q.push_back(e);
    if (r) begin
      slot.delete();
      m_era = '0; m_ecode = '0; m_cnt = 0;
      known = 1; post_rst = 1;
      return;
    end
    post_rst = 0;
    if (e.valid && oa) begin
      f = slot.pop_front();
      if (f.exc) begin
        m_era = f.pc; m_ecode = f.ecode;
      end else begin
        m_cnt++;
      end
      if (f.exc || f.ertn) return;
    end
    if (slot.size() == 0 && mv)
      slot.push_back(in);
  endtask

  task automatic cyc(bit r, bit mv, bit oa,
                     ins_t in);
    @(negedge clk);
    rst = r; ma_validout = mv;
    other_allowin = oa; bus = pack(in);
    step(r, mv, oa, in);
  endtask

  task automatic check(exp_t e);
    logic [63:0] c;
    c = e.cnt;
    chk("validout", wb_validout, e.valid);
    chk("allowin", ma_if.wb_allowin, e.allowin);
    chk("retired_cnt", retired_cnt, c);
    chk("retired_cnt4", cnt4, c[3:0]);
    chk("csr_era", csr_era, e.era);
    chk("csr_ecode", csr_ecode, e.ecode);
    chk("flush", wb_flush, e.flush);
    chk("flush4", fl4, e.flush);
    chk("rf_we", wb_rf_we, e.rf_we);
    chk("fwd_valid", wb_fwd_valid, e.rf_we);
    chk("dbg_we", debug_wb_rf_we, {4{e.rf_we}});
    if (e.valid) begin
      chk("waddr", wb_rf_waddr, e.waddr);
      chk("wdata", wb_rf_wdata, e.wdata);
      chk("fwd_dest", wb_fwd_dest, e.waddr);
      chk("fwd_data", wb_fwd_data, e.wdata);
      chk("target", wb_flush_target, e.target);
      chk("dbg_pc", debug_wb_pc, e.pc);
      chk("dbg_wnum", debug_wb_rf_wnum, e.waddr);
      chk("dbg_wdata", debug_wb_rf_wdata, e.wdata);
    end else begin
      chk("fwd_dest_inv", wb_fwd_dest, 0);
    end
    if (e.post_rst) begin
      chk("rst_waddr", wb_rf_waddr, 0);
      chk("rst_wdata", wb_rf_wdata, 0);
      chk("rst_fdata", wb_fwd_data, 0);
      chk("rst_target", wb_flush_target, 0);
      chk("rst_pc", debug_wb_pc, 0);
      chk("rst_wnum", debug_wb_rf_wnum, 0);
    end
  endtask

  // Monitor: one expected record per cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL sb_empty: got 0 want 1");
      end else begin
        e = exp_q.pop_front();
        if (!e.skip) check(e);
      end
    end
  end

  initial begin
    ins_t z;
    z = mk(0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, z);
    cyc(1, 0, 0, z);
    cyc(0, 0, 1, z);
    // back-to-back r1..r3
    cyc(0, 1, 1, mk(1, 0, 0, 0, 1, 5, 32'h100));
    cyc(0, 1, 1, mk(1, 0, 0, 0, 2, 6, 32'h104));
    cyc(0, 1, 1, mk(1, 0, 0, 0, 3, 7, 32'h108));
    cyc(0, 0, 1, z);
    // stall four cycles, then release
    cyc(0, 1, 1, mk(1, 0, 0, 0, 9, 99, 32'h10c));
    for (int i = 0; i < 4; i++)
      cyc(0, 1, 0, rnd_ins());
    cyc(0, 0, 1, z);
    cyc(0, 0, 1, z);
    // exception with a concurrent instruction
    cyc(0, 1, 1,
        mk(1, 1, 0, 6'h0b, 4, 1, 32'h1c000040));
    cyc(0, 1, 1, mk(1, 0, 0, 0, 5, 55, 32'h200));
    cyc(0, 0, 1, z);
    // ertn, then exc+ertn together
    cyc(0, 1, 1, mk(0, 0, 1, 0, 0, 0, 32'h300));
    cyc(0, 0, 1, z);
    cyc(0, 1, 1, mk(0, 1, 1, 6'h0c, 0, 0, 32'h400));
    cyc(0, 0, 1, z);
    // dest 0 never writes
    cyc(0, 1, 1, mk(1, 0, 0, 0, 0, 77, 32'h500));
    cyc(0, 0, 1, z);
    // 17 commits from reset
    cyc(1, 0, 0, z);
    for (int i = 0; i < 17; i++)
      cyc(0, 1, 1, mk(1, 0, 0, 0, 5'(i + 1),
                      32'(i), 32'(i * 4)));
    cyc(0, 0, 1, z);
    cyc(0, 0, 1, z);
    // randomized traffic
    for (int i = 0; i < 1500; i++)
      cyc(0, $urandom % 4 != 0,
          $urandom % 3 != 0, rnd_ins());
    // reset while a valid entry is stalled
    cyc(0, 0, 1, z);
    cyc(0, 1, 1, mk(1, 0, 0, 0, 6, 66, 32'h600));
    cyc(0, 0, 0, z);
    cyc(1, 0, 0, z);
    cyc(0, 0, 1, z);
    cyc(0, 0, 1, z);
    #3;
    chk("sb_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
